// File: rtl/apb_slave_bridge_if.sv
// Bundle of the APB4 completer signals and the register-backend handshake
// that apb_slave_bridge sits between.
interface apb_slave_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 12
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  logic [REG_AW-1:0]     reg_addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ack;
  logic                  error;

  // Bridge side: consumes APB requests and backend responses.
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr,
    output reg_addr, wr_en, rd_en, wdata, wstrb,
    input  rdata, ack, error
  );

  // Environment side: APB requester plus register backend.
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr,
    input  reg_addr, wr_en, rd_en, wdata, wstrb,
    output rdata, ack, error
  );
endinterface

// File: rtl/apb_slave_bridge.sv
// APB4 slave to register-backend bridge: decodes a base window, issues one
// wr_en/rd_en strobe per hit, waits for ack with a timeout, answers on PREADY.
module apb_slave_bridge #(
  parameter int                        ADDR_W      = 32,
  parameter int                        DATA_W      = 32,
  parameter int                        REG_AW      = 12,
  parameter logic [ADDR_W-REG_AW-1:0]  BASE_ADDR   = 20'h4_0001,
  parameter bit                        CHECK_ALIGN = 1'b1,
  parameter int                        TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  apb_slave_bridge_if.slave bus
);
  localparam int STRB_W  = DATA_W / 8;
  localparam int ALIGN_W = $clog2(STRB_W);
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              err_q;
  logic [REG_AW-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] cap_q;

  logic setup, aligned, hit, busy, tmo, ack_take, tmo_take;

  assign setup    = (state == IDLE) && bus.psel && !bus.penable;
  assign aligned  = (bus.paddr[ALIGN_W-1:0] == '0);
  assign hit      = (bus.paddr[ADDR_W-1:REG_AW] == BASE_ADDR) && (aligned || !CHECK_ALIGN);
  assign busy     = ((state == REQ) || (state == WAIT)) && bus.psel;
  assign tmo      = (cnt == CNT_W'(TIMEOUT - 1));
  assign ack_take = busy && bus.ack;
  // In WAIT an ack in the same cycle as the last counter value still wins.
  assign tmo_take = busy && (state == WAIT) && !bus.ack && tmo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (setup)
        err_q <= !hit;
      else if (ack_take)
        err_q <= bus.error;
      else if (tmo_take)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: if (setup) state_d = hit ? REQ : DONE;
      REQ: begin
        if (!bus.psel)
          state_d = IDLE;
        else if (bus.ack)
          state_d = DONE;
        else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (!bus.psel)
          state_d = IDLE;
        else if (bus.ack || tmo)
          state_d = DONE;
        else
          cnt_d = cnt + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request/response latches carry no reset; outputs are gated by state.
  always_ff @(posedge clk) begin
    if (setup) begin
      addr_q  <= bus.paddr[REG_AW-1:0];
      wr_q    <= bus.pwrite;
      wdata_q <= bus.pwdata;
      wstrb_q <= bus.pstrb;
    end
    if (ack_take)
      cap_q <= wr_q ? '0 : bus.rdata;
    else if (tmo_take)
      cap_q <= '0;
  end

  assign bus.pready   = (state == DONE);
  assign bus.pslverr  = (state == DONE) && err_q;
  assign bus.prdata   = ((state == DONE) && !err_q && !wr_q) ? cap_q : '0;
  assign bus.wr_en    = (state == REQ) && wr_q;
  assign bus.rd_en    = (state == REQ) && !wr_q;
  assign bus.reg_addr = (state != IDLE) ? addr_q : '0;
  assign bus.wdata    = ((state != IDLE) && wr_q) ? wdata_q : '0;
  assign bus.wstrb    = ((state != IDLE) && wr_q) ? wstrb_q : '0;
endmodule

// File: tb/tb_apb_slave_bridge.sv
// Self-checking bench for apb_slave_bridge: directed transfers followed by
// randomized ones, checked cycle by cycle against a latency/response model.
module tb_apb_slave_bridge;
  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam int          REG_AW  = 12;
  localparam int          TIMEOUT = 15;
  localparam logic [19:0] BASE    = 20'h4_0001;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  apb_slave_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();
  apb_slave_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW)) bus2 ();

  assign bus2.psel    = bus.psel;
  assign bus2.penable = bus.penable;
  assign bus2.pwrite  = bus.pwrite;
  assign bus2.paddr   = bus.paddr;
  assign bus2.pwdata  = bus.pwdata;
  assign bus2.pstrb   = bus.pstrb;
  assign bus2.rdata   = bus.rdata;
  assign bus2.ack     = bus.ack;
  assign bus2.error   = bus.error;

  apb_slave_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW),
    .BASE_ADDR(BASE), .CHECK_ALIGN(1'b1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  apb_slave_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW),
    .BASE_ADDR(BASE), .CHECK_ALIGN(1'b0), .TIMEOUT(TIMEOUT)
  ) dut_noalign (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_outputs",
          {60'd0, bus.pready, bus.pslverr, bus.wr_en, bus.rd_en} |
          {32'd0, bus.prdata} | {32'd0, bus.wdata} |
          {52'd0, bus.reg_addr} | {60'd0, bus.wstrb}, 64'd0);
    end
  endtask

  // One APB transfer; d = cycles after the strobe cycle at which ack is given
  // (0 = in the strobe cycle, negative = never).
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                      input logic [3:0] st, input int d, input bit er,
                      input logic [31:0] ack_rd);
    bit          upper, hit, err_exp;
    int          kd;
    logic [31:0] rd_exp;
    upper = (addr[31:12] == BASE);
    hit   = upper && (addr[1:0] == 2'b00);
    if (!hit) begin
      kd = 1; err_exp = 1'b1;
    end else if (d >= 0 && d <= TIMEOUT) begin
      kd = d + 2; err_exp = er;
    end else begin
      kd = TIMEOUT + 2; err_exp = 1'b1;
    end
    rd_exp = (!wr && !err_exp) ? ack_rd : 32'd0;

    @(negedge clk);
    chk("t0_pready", bus.pready, 1'b0);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr;
    bus.pwdata = wd; bus.pstrb = st; bus.ack = 1'b0;
    bus.error = 1'($urandom); bus.rdata = $urandom;
    for (int k = 1; k <= kd; k++) begin
      @(negedge clk);
      chk("pready", bus.pready, k == kd);
      chk("pslverr", bus.pslverr, (k == kd) && err_exp);
      chk("prdata", bus.prdata, (k == kd) ? rd_exp : 32'd0);
      chk("wr_en", bus.wr_en, hit && (k == 1) && wr);
      chk("rd_en", bus.rd_en, hit && (k == 1) && !wr);
      if (k == 1)
        chk("strobe_noalign", {bus2.wr_en, bus2.rd_en},
            upper ? (wr ? 2'b10 : 2'b01) : 2'b00);
      if (hit) begin
        chk("reg_addr", bus.reg_addr, addr[11:0]);
        chk("wdata", bus.wdata, wr ? wd : 32'd0);
        chk("wstrb", bus.wstrb, wr ? st : 4'd0);
      end
      if (k == kd) begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.ack = 1'b0;
      end else begin
        bus.penable = 1'b1;
        bus.ack     = hit && (k == d + 1);
        bus.rdata   = bus.ack ? ack_rd : $urandom;
        bus.error   = bus.ack ? er : 1'($urandom);
      end
    end
  endtask

  // Hit transfer dropped by the requester after ka cycles, then a late ack.
  task automatic abort_xfer(input logic [31:0] addr, input bit wr, input int ka);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr;
    bus.pwdata = $urandom; bus.pstrb = 4'hF; bus.ack = 1'b0;
    for (int k = 1; k <= ka; k++) begin
      @(negedge clk);
      chk("abort_strobe", {bus.wr_en, bus.rd_en}, (k == 1) ? (wr ? 2'b10 : 2'b01) : 2'b00);
      chk("abort_pready", bus.pready, 1'b0);
      if (k == ka) begin
        bus.psel = 1'b0; bus.penable = 1'b0;
      end else
        bus.penable = 1'b1;
    end
    bus.ack = 1'b1; bus.rdata = $urandom; bus.error = 1'b1;
    idle_chk(2);
    bus.ack = 1'b0; bus.error = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          sel, dsel, dd;
    rst_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0;
    bus.pwdata = '0; bus.pstrb = '0; bus.rdata = '0; bus.ack = 1'b0; bus.error = 1'b0;
    repeat (2) @(negedge clk);
    idle_chk(1);
    rst_n = 1'b1;
    idle_chk(1);

    xfer(32'h4000_1010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, $urandom);
    xfer(32'h4000_1004, 1'b0, $urandom, 4'h5, 3, 1'b0, 32'h1234_5678);
    xfer(32'h4000_2000, 1'b0, $urandom, 4'hF, 0, 1'b0, $urandom);
    xfer(32'h4000_1002, 1'b0, $urandom, 4'hF, 0, 1'b0, $urandom);
    xfer(32'h4000_1020, 1'b1, 32'hCAFE_F00D, 4'h3, -1, 1'b0, $urandom);
    bus.ack = 1'b1;
    idle_chk(2);
    bus.ack = 1'b0;
    xfer(32'h4000_1024, 1'b1, 32'h0BAD_CAFE, 4'hC, 2, 1'b1, $urandom);
    xfer(32'h4000_1028, 1'b0, $urandom, 4'hF, TIMEOUT, 1'b0, 32'hA5A5_5A5A);

    // Reset while waiting for ack, then an access phase with no setup.
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h4000_1008;
    @(negedge clk); bus.penable = 1'b1;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    idle_chk(1);
    rst_n = 1'b1;
    idle_chk(1);
    bus.psel = 1'b0; bus.penable = 1'b0;
    xfer(32'h4000_1008, 1'b0, $urandom, 4'hF, 1, 1'b0, 32'h0F0F_1234);

    abort_xfer(32'h4000_1030, 1'b1, 1);
    abort_xfer(32'h4000_1034, 1'b0, 4);

    for (int i = 0; i < 60; i++) begin
      sel  = $urandom_range(0, 3);
      dsel = $urandom_range(0, 7);
      case (sel)
        0, 1:    a = {BASE, 12'($urandom) & 12'hFFC};
        2:       a = $urandom;
        default: a = {BASE, 12'($urandom)};
      endcase
      case (dsel)
        5:       dd = TIMEOUT;
        6:       dd = TIMEOUT + 1;
        7:       dd = -1;
        default: dd = dsel;
      endcase
      xfer(a, 1'($urandom), $urandom, 4'($urandom), dd, ($urandom_range(0, 3) == 0), $urandom);
      idle_chk($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
